// File: rtl/platform_collision.sv
// -----------------------------------------------------------------------------
// platform_collision
//
// Frame-rate landing detector for the falling ball. Each rising edge of
// frame_clk snapshots the platform and ball inputs. The block then walks all
// NPLAT platforms, one per Clk cycle, and reports whether the ball has come
// down onto a platform top. The lowest-index hit wins.
//
// Optional feature: define PLATFORM_COLLISION_COUNT_EN to add the saturating
// land_count output.
//
// Ports
//   Clk, Reset        : system clock; synchronous active-high reset
//   frame_clk         : frame tick (level); its synchronised rising edge starts a scan
//   plat_x_flat/_y    : NPLAT packed 9-bit platform centres, platform k at [9k+8:9k]
//   plat_sizeX/Y      : shared platform half-width / half-height
//   BallX/BallY       : ball centre
//   Ball_size         : ball half-size
//   ball_falling      : ball Y velocity is downward
//   busy              : scan in progress (SCAN and DONE)
//   done              : one-cycle pulse, scan result valid
//   land              : a landing was found (valid with done, held afterwards)
//   hit_idx           : index of the landed platform (0 when no landing)
//   land_y            : ball centre Y resting exactly on that platform (0 when no landing)
//   overrun           : sticky, a frame edge arrived while busy
//   land_count        : saturating landing counter (macro builds only)
// -----------------------------------------------------------------------------
module platform_collision #(
    parameter int NPLAT    = 16,
    parameter int LAND_TOL = 6
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [9*NPLAT-1:0]   plat_x_flat,
    input  logic [9*NPLAT-1:0]   plat_y_flat,
    input  logic [8:0]           plat_sizeX,
    input  logic [8:0]           plat_sizeY,
    input  logic [9:0]           BallX,
    input  logic [9:0]           BallY,
    input  logic [9:0]           Ball_size,
    input  logic                 ball_falling,
    output logic                 busy,
    output logic                 done,
    output logic                 land,
    output logic [3:0]           hit_idx,
    output logic [9:0]           land_y,
`ifdef PLATFORM_COLLISION_COUNT_EN
    output logic [15:0]          land_count,
`endif
    output logic                 overrun
);

    localparam int IDXW = $clog2(NPLAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------------
    // frame_clk synchroniser and rising-edge detect
    // ---------------------------------------------------------------------
    logic sync1_q, sync2_q, dly_q;
    logic frame_rise;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source.
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign frame_rise = sync2_q & ~dly_q;

    // ---------------------------------------------------------------------
    // Input snapshot, loaded only when a scan starts
    // ---------------------------------------------------------------------
    logic       capture;
    logic [8:0] px_s_q [NPLAT];
    logic [8:0] py_s_q [NPLAT];
    logic [8:0] sx_s_q, sy_s_q;
    logic [9:0] bx_s_q, by_s_q, bs_s_q;
    logic       fall_s_q;

    // NOTE: the snapshot is a plain data store with no reset; it is always
    // written in the capture cycle before the scan ever reads it.
    always_ff @(posedge Clk) begin
        if (capture) begin
            for (int k = 0; k < NPLAT; k++) begin
                px_s_q[k] <= plat_x_flat[9*k +: 9];
                py_s_q[k] <= plat_y_flat[9*k +: 9];
            end
            sx_s_q   <= plat_sizeX;
            sy_s_q   <= plat_sizeY;
            bx_s_q   <= BallX;
            by_s_q   <= BallY;
            bs_s_q   <= Ball_size;
            fall_s_q <= ball_falling;
        end
    end

    // ---------------------------------------------------------------------
    // Hit test for the platform currently addressed by idx_q. All terms are
    // zero-extended to 11 bits and arranged so nothing is subtracted.
    // ---------------------------------------------------------------------
    logic [IDXW-1:0] idx_q, idx_d;
    logic [10:0] px, py, sx, sy, bx, by, bs;
    logic [10:0] plat_reach, ball_reach, ball_b, win_hi, rest_off;
    logic        hit;
    logic [9:0]  cur_land_y;

    always_comb begin
        px = {2'b00, px_s_q[idx_q]};
        py = {2'b00, py_s_q[idx_q]};
        sx = {2'b00, sx_s_q};
        sy = {2'b00, sy_s_q};
        bx = {1'b0, bx_s_q};
        by = {1'b0, by_s_q};
        bs = {1'b0, bs_s_q};

        plat_reach = px + sx + bs;
        ball_reach = bx + bs + sx;
        ball_b     = by + bs + sy;
        win_hi     = py + 11'(LAND_TOL);
        rest_off   = sy + bs;

        hit = fall_s_q
            && (plat_reach >= bx)
            && (ball_reach >= px)
            && (ball_b >= py)
            && (ball_b <= win_hi);

        // Clamp to the screen top when the platform sits too high to rest on.
        cur_land_y = (py < rest_off) ? 10'd0 : 10'(py - rest_off);
    end

    // ---------------------------------------------------------------------
    // Scan FSM
    // ---------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            found_q, found_d;
    logic [IDXW-1:0] cand_idx_q, cand_idx_d;
    logic [9:0]      cand_y_q, cand_y_d;
    logic            land_q, land_d;
    logic [IDXW-1:0] hit_idx_q, hit_idx_d;
    logic [9:0]      land_y_q, land_y_d;
    logic            overrun_q, overrun_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        found_d    = found_q;
        cand_idx_d = cand_idx_q;
        cand_y_d   = cand_y_q;
        land_d     = land_q;
        hit_idx_d  = hit_idx_q;
        land_y_d   = land_y_q;
        overrun_d  = overrun_q;
        capture    = 1'b0;

        // NOTE: combinational blocks use blocking assignments, so found_d and
        // cand_*_d below already include this cycle's hit when read back.
        unique case (state_q)
            S_IDLE: begin
                if (frame_rise) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    found_d = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (frame_rise) overrun_d = 1'b1;
                // First hit sticks; later platforms cannot displace it.
                if (hit && !found_q) begin
                    found_d    = 1'b1;
                    cand_idx_d = idx_q;
                    cand_y_d   = cur_land_y;
                end
                if (idx_q == IDXW'(NPLAT - 1)) begin
                    state_d   = S_DONE;
                    land_d    = found_d;
                    hit_idx_d = found_d ? cand_idx_d : '0;
                    land_y_d  = found_d ? cand_y_d   : '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (frame_rise) overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            found_q    <= 1'b0;
            cand_idx_q <= '0;
            cand_y_q   <= '0;
            land_q     <= 1'b0;
            hit_idx_q  <= '0;
            land_y_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            found_q    <= found_d;
            cand_idx_q <= cand_idx_d;
            cand_y_q   <= cand_y_d;
            land_q     <= land_d;
            hit_idx_q  <= hit_idx_d;
            land_y_q   <= land_y_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign land    = land_q;
    assign hit_idx = 4'(hit_idx_q);
    assign land_y  = land_y_q;
    assign overrun = overrun_q;

`ifdef PLATFORM_COLLISION_COUNT_EN
    // ---------------------------------------------------------------------
    // Saturating landing counter, bumped once per DONE that reports a landing
    // ---------------------------------------------------------------------
    logic [15:0] land_count_q, land_count_d;

    always_comb begin
        land_count_d = land_count_q;
        if (state_q == S_DONE && land_q && land_count_q != 16'hFFFF)
            land_count_d = land_count_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) land_count_q <= '0;
        else       land_count_q <= land_count_d;
    end

    assign land_count = land_count_q;
`endif

endmodule

// File: tb/tb_platform_collision.sv
// -----------------------------------------------------------------------------
// tb_platform_collision
//
// Self-checking bench for platform_collision. Directed frames cover reset,
// basic landing, rising ball, horizontal miss, priority, the tolerance edge,
// land_y clamping, input isolation, overrun and mid-scan abort. Randomised
// frames are compared against a behavioural model that applies the landing
// rules directly to the platform list.
// -----------------------------------------------------------------------------
module tb_platform_collision;

    localparam int NPLAT = 16;

    logic          Clk;
    logic          Reset;
    logic          frame_clk;
    logic [143:0]  plat_x_flat, plat_y_flat;
    logic [8:0]    plat_sizeX, plat_sizeY;
    logic [9:0]    BallX, BallY, Ball_size;
    logic          ball_falling;
    logic          busy, done, land, overrun;
    logic [3:0]    hit_idx;
    logic [9:0]    land_y;
`ifdef PLATFORM_COLLISION_COUNT_EN
    logic [15:0]   land_count;
`endif

    logic [8:0] px [NPLAT];
    logic [8:0] py [NPLAT];

    int n_checks  = 0;
    int n_pass    = 0;
    int exp_count = 0;

    for (genvar g = 0; g < NPLAT; g++) begin : g_pack
        assign plat_x_flat[9*g +: 9] = px[g];
        assign plat_y_flat[9*g +: 9] = py[g];
    end

    platform_collision #(.NPLAT(16), .LAND_TOL(6)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .plat_x_flat  (plat_x_flat),
        .plat_y_flat  (plat_y_flat),
        .plat_sizeX   (plat_sizeX),
        .plat_sizeY   (plat_sizeY),
        .BallX        (BallX),
        .BallY        (BallY),
        .Ball_size    (Ball_size),
        .ball_falling (ball_falling),
        .busy         (busy),
        .done         (done),
        .land         (land),
        .hit_idx      (hit_idx),
        .land_y       (land_y),
`ifdef PLATFORM_COLLISION_COUNT_EN
        .land_count   (land_count),
`endif
        .overrun      (overrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a platform is landed on when the ball is falling,
    // the horizontal extents touch, and the ball bottom measured against
    // the platform centre lies within LAND_TOL below the platform top.
    // Sums wrap at 11 bits like the hardware comparators.
    // ---------------------------------------------------------------------
    function automatic bit model_hit(input int k);
        int pxk, pyk, sx, sy, bx, by, bs, b;
        pxk = int'(px[k]); pyk = int'(py[k]);
        sx = int'(plat_sizeX); sy = int'(plat_sizeY);
        bx = int'(BallX); by = int'(BallY); bs = int'(Ball_size);
        b  = (by + bs + sy) % 2048;
        return ball_falling
            && (((pxk + sx + bs) % 2048) >= bx)
            && (((bx + bs + sx) % 2048) >= pxk)
            && (b >= pyk) && (b <= pyk + 6);
    endfunction

    function automatic void ref_model(output bit l, output int idx, output int y);
        int rest;
        l = 0; idx = 0; y = 0;
        for (int k = 0; k < NPLAT; k++) begin
            if (!l && model_hit(k)) begin
                l    = 1;
                idx  = k;
                rest = int'(plat_sizeY) + int'(Ball_size);
                y    = (int'(py[k]) >= rest) ? int'(py[k]) - rest : 0;
            end
        end
    endfunction

    task automatic clear_plats();
        for (int k = 0; k < NPLAT; k++) begin
            px[k] = '0;
            py[k] = '0;
        end
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < NPLAT; k++) begin
            px[k] = 9'($urandom);
            py[k] = 9'($urandom);
        end
        BallX        = 10'($urandom);
        BallY        = 10'($urandom);
        ball_falling = ~ball_falling;
    endtask

    // Run one frame: raise frame_clk, wait (bounded) for done, check the
    // result against the model computed from the inputs present at the edge.
    task automatic run_frame(input string tag, input bit scramble);
        bit el;
        int ei, ey, cyc, busy_n;
        bit got, scr_done;
        ref_model(el, ei, ey);
        cyc = 0; busy_n = 0; got = 0; scr_done = 0;
        frame_clk = 1'b1;
        while (!got && cyc < 60) begin
            tick();
            cyc++;
            if (busy) begin
                busy_n++;
                if (scramble && !scr_done) begin
                    scramble_inputs();
                    scr_done = 1;
                end
            end
            if (done) got = 1;
        end
        check({tag, ".done_seen"}, got, 1);
        if (got) begin
            check({tag, ".busy_len"}, busy_n, 17);
            check({tag, ".land"}, land, el);
            check({tag, ".hit_idx"}, hit_idx, ei);
            check({tag, ".land_y"}, land_y, ey);
            if (el) exp_count++;
        end
        frame_clk = 1'b0;
        tick();
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".held_land"}, land, el);
        repeat (3) tick();
    endtask

    task automatic setup_simple();
        clear_plats();
        px[3] = 9'd200; py[3] = 9'd120;
        plat_sizeX = 9'd10; plat_sizeY = 9'd4;
        BallX = 10'd205; BallY = 10'd110; Ball_size = 10'd8;
        ball_falling = 1'b1;
    endtask

    task automatic random_frame();
        int b;
        clear_plats();
        plat_sizeX   = 9'($urandom_range(4, 40));
        plat_sizeY   = 9'($urandom_range(2, 10));
        Ball_size    = 10'($urandom_range(2, 20));
        BallX        = 10'($urandom_range(50, 450));
        BallY        = 10'($urandom_range(20, 300));
        ball_falling = ($urandom_range(0, 4) != 0);
        b = int'(BallY) + int'(Ball_size) + int'(plat_sizeY);
        for (int k = 0; k < NPLAT; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                px[k] = 9'(int'(BallX) + $urandom_range(0, 100) - 50);
                py[k] = 9'(b - $urandom_range(0, 9));
            end else begin
                px[k] = 9'($urandom);
                py[k] = 9'($urandom);
            end
        end
    endtask

    initial begin
        int dones, cyc;
        Reset = 1'b1; frame_clk = 1'b0;
        clear_plats();
        plat_sizeX = '0; plat_sizeY = '0;
        BallX = '0; BallY = '0; Ball_size = '0; ball_falling = 1'b0;

        // ---- reset ----
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.land", land, 0);
        check("rst.hit_idx", hit_idx, 0);
        check("rst.land_y", land_y, 0);
        check("rst.overrun", overrun, 0);
`ifdef PLATFORM_COLLISION_COUNT_EN
        check("rst.land_count", land_count, 0);
`endif
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) dones++;
        end
        check("rst.no_done", dones, 0);

        // ---- directed frames ----
        setup_simple();
        check("simple.model_hit3", model_hit(3), 1);
        run_frame("simple", 0);
        check("simple.idx_const", hit_idx, 3);
        check("simple.y_const", land_y, 108);

        setup_simple(); ball_falling = 1'b0;
        run_frame("rising", 0);
        setup_simple(); BallX = 10'd230;
        run_frame("hmiss", 0);

        clear_plats();
        px[2] = 9'd100; py[2] = 9'd90; px[9] = 9'd100; py[9] = 9'd90;
        plat_sizeX = 9'd10; plat_sizeY = 9'd4;
        BallX = 10'd100; BallY = 10'd78; Ball_size = 10'd8; ball_falling = 1'b1;
        run_frame("prio", 0);
        check("prio.idx_const", hit_idx, 2);
        BallY = 10'd84;
        run_frame("tol_edge", 0);
        check("tol_edge.land_const", land, 1);
        BallY = 10'd85;
        run_frame("tol_miss", 0);
        check("tol_miss.land_const", land, 0);

        clear_plats();
        px[0] = 9'd100; py[0] = 9'd8;
        plat_sizeX = 9'd10; plat_sizeY = 9'd4;
        BallX = 10'd100; BallY = 10'd0; Ball_size = 10'd8; ball_falling = 1'b1;
        run_frame("clamp", 0);

        setup_simple();
        run_frame("isolate", 1);

        // ---- randomised frames ----
        for (int i = 0; i < 30; i++) begin
            random_frame();
            run_frame($sformatf("rand%0d", i), 0);
        end

        // ---- overrun: second edge while busy ----
        setup_simple();
        frame_clk = 1'b1;
        dones = 0; cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ovr.busy_seen", busy, 1);
        repeat (2) tick();
        frame_clk = 1'b0;
        repeat (4) tick();
        if (done) dones++;
        frame_clk = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) dones++;
        end
        check("ovr.one_done", dones, 1);
        check("ovr.flag", overrun, 1);
        frame_clk = 1'b0;
        repeat (4) tick();
        check("ovr.sticky", overrun, 1);
        run_frame("ovr_next", 0);
        check("ovr.sticky2", overrun, 1);

        // ---- abort mid-scan ----
        setup_simple();
        frame_clk = 1'b1;
        cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        repeat (7) tick();
        Reset = 1'b1; frame_clk = 1'b0;
        tick();
        check("abort.busy_in_rst", busy, 0);
        check("abort.done_in_rst", done, 0);
        check("abort.land_in_rst", land, 0);
        check("abort.idx_in_rst", hit_idx, 0);
        check("abort.y_in_rst", land_y, 0);
        check("abort.ovr_in_rst", overrun, 0);
        tick();
        Reset = 1'b0;
        exp_count = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        check("abort.no_done", dones, 0);

        // ---- landing count ----
        for (int i = 0; i < 3; i++) begin
            setup_simple();
            run_frame($sformatf("cnt%0d", i), 0);
        end
        setup_simple(); ball_falling = 1'b0;
        run_frame("cnt_miss", 0);
`ifdef PLATFORM_COLLISION_COUNT_EN
        check("cnt.land_count", land_count, exp_count);
        check("cnt.land_count3", land_count, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
